// File: rtl/clmul_pp_split.sv
// Sequential carry-less partial-product generator: z0/z1/z2/o recombine to a*b over GF(2).
// Latency W-2 cycles from accept to out_valid; in_ready low while BUSY/DONE, outputs held until out_ready.
// Optional CLMUL_PP_MASK_EN: per-operation LFSR mask folded into o and z1.
module clmul_pp_split #(
    parameter int             W         = 8,
    parameter logic [W-2:0]   LFSR_SEED = 7'h5B
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       z0,
    output logic [2*W-2:0]     z1,
    output logic [W-1:0]       z2,
    output logic [W-2:0]       o
);
    localparam int CW = $clog2(W);
    localparam int PW = 2*W-1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [PW-1:0]   row_cnt;
    logic [W-2:0]    mask;
    logic            accept;

    assign accept = in_valid & in_ready;

    always_comb begin
        row_cnt = '0;
        row_cnt = {{(W-1){1'b0}}, a_q & {W{b_q[cnt]}}} << cnt;
    end

`ifdef CLMUL_PP_MASK_EN
    logic [W-2:0] lfsr;

    // Fibonacci LFSR x^7+x^6+1; steps once per accepted operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else if (accept)
            lfsr <= {lfsr[W-3:0], lfsr[W-2] ^ lfsr[W-3]};
    end

    assign mask = lfsr;
`else
    assign mask = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            z0        <= '0;
            z1        <= '0;
            z2        <= '0;
            o         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q      <= a;
                        b_q      <= b;
                        z0       <= a & {W{b[0]}};
                        z2       <= a & {W{b[W-1]}};
                        // mask cancels between o and z1 in the recombiner
                        z1       <= {mask, 1'b0, mask};
                        o        <= mask;
                        cnt      <= CW'(1);
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    z1  <= z1 ^ row_cnt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W-2)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/clmul_pp_split.md
Name: clmul_pp_split

Overview:
- Sequential partial-product generator for the carry-less (GF(2)) multiply path; it is the producer side of the 16-bit output-stage recombiner.
- Accepts two W-bit operands and computes shift-and-XOR partial-product rows iteratively.
- Emits the operand set z0/z1/z2/o such that the output-stage recombination equals the carry-less product a·b.
- Sits between the operand issue stage and the combinational output stage, with valid/ready on both sides.

Parameters:
- W, 8, operand width. Derived widths: z0 = W, z1 = 2W-1, z2 = W, o = W-1.
- LFSR_SEED, 7'h5B, reset value of the mask LFSR. Used only with the optional feature; must be nonzero.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  W  multiplicand.
- b  in  W  multiplier.
- out_valid  out  1  z0/z1/z2/o valid.
- out_ready  in  1  downstream accepts the result.
- z0  out  W  row 0 term; feeds product bits [W-1:0].
- z1  out  2W-1  XOR of rows 1..W-2; feeds product bits [2W-2:0].
- z2  out  W  row W-1 term; feeds product bits [2W-2:W-1].
- o  out  W-1  overlap/mask term; feeds bits k and k+W.

Behaviour:
- Recombination contract, with P = a·b over GF(2):
  - k < W-1: P[k] = z1[k]^z0[k]^o[k].
  - k = W-1: P[W-1] = z2[0]^z1[W-1]^z0[W-1].
  - k ≥ W: P[k] = z1[k]^z2[k-W+1]^o[k-W].
- Row definition: row_i = (a & {W{b[i]}}) << i.
- States: IDLE, BUSY, DONE.
- Reset (async, rst_n low): state = IDLE; in_ready = 1; out_valid = 0; z0/z1/z2/o = 0; counter = 0; LFSR = LFSR_SEED.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at edge T: latch a and b; z0 <= row_0; z2 <= a & {W{b[W-1]}}; z1 <= 0; o <= 0 (or the mask, see feature); cnt <= 1; go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each edge: z1 <= z1 ^ row_cnt; cnt++.
  - On the edge that processes cnt = W-2: go to DONE and set out_valid = 1.
  - For W = 8: out_valid is visible after edge T+6, i.e. 6-cycle latency from accept.
- DONE:
  - out_valid = 1; z0/z1/z2/o held stable.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
  - in_ready is 0 in DONE, so there is no overlap with a new operand. Next accept is possible one cycle after handoff.
- Boundaries:
  - b = 0 or a = 0: all outputs 0; full latency is still taken (no early exit).
  - in_valid asserted during BUSY/DONE is ignored; a/b changes there have no effect.
  - out_ready held low keeps outputs frozen indefinitely.
  - rst_n asserted mid-BUSY or in DONE aborts immediately to reset values; the partial result is discarded and never presented.
  - W ≥ 3 required; cnt width = clog2(W).

Optional Feature:
- Macro: CLMUL_PP_MASK_EN.
- Defined:
  - A (W-1)-bit Fibonacci LFSR (maximal-length taps for W-1 = 7: x^7+x^6+1) advances on every accept.
  - At accept: o <= LFSR value and z1 <= {o, 1'b0, o}; the BUSY rows then XOR into that.
  - The recombined P is unchanged, but the individual terms are masked per operation.
- Undefined: o is constant 0, no LFSR is instantiated, and z1 starts from 0.

Test Plan:
- Full-ones: a = 0xFF, b = 0xFF, out_ready = 1 → out_valid at T+6 with z0 = 0xFF, z2 = 0xFF, z1 = 0x2A2A, o = 0; recombined P = 0x5555.
- Edge rows: a = 0x03, b = 0x81 → z0 = 0x03, z2 = 0x03, z1 = 0x0000, o = 0; P = 0x0183.
- Zero operand and latency: a = 0x00, b = 0xA5 → all outputs 0, out_valid exactly at T+6; in_ready = 0 from T+1 until the handoff.
- Backpressure: a = 0x0B, b = 0x0D with out_ready low for 10 cycles → outputs frozen, in_valid pulses ignored; handoff on the first out_ready = 1 cycle; in_ready = 1 on the next cycle; P = 0x007F.
- Reset mid-op: rst_n low at T+3 → out_valid = 0 and all outputs 0 immediately. A following op a = 0x02, b = 0x03 yields P = 0x0006 with no stale data.
- With CLMUL_PP_MASK_EN: 256 random operand pairs → o is nonzero on at least one op, o differs between consecutive ops, and recombined P always equals the reference clmul.
